// File: rtl/ahb_master_biu.sv
// AHB-Lite master bus interface: arbitrates NUM_PORTS requesters onto a two-stage
// (address/data) pipeline issuing SINGLE transfers, with two-cycle ERROR handling.
module ahb_master_biu #(
  parameter int    NUM_PORTS = 2,
  parameter int    ADDR_W    = 32,
  parameter int    DATA_W    = 32,
  parameter string ARB_MODE  = "FIXED"
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        p_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
  input  logic [NUM_PORTS-1:0]        p_write,
  input  logic [NUM_PORTS*3-1:0]      p_size,
  input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
  output logic [NUM_PORTS-1:0]        p_ack,
  output logic [NUM_PORTS-1:0]        p_done,
  output logic [NUM_PORTS-1:0]        p_err,
  output logic [DATA_W-1:0]           p_rdata,
  output logic [ADDR_W-1:0]           HADDR,
  output logic [1:0]                  HTRANS,
  output logic                        HWRITE,
  output logic [2:0]                  HSIZE,
  output logic [DATA_W-1:0]           HWDATA,
  output logic [2:0]                  HBURST,
  output logic [3:0]                  HPROT,
  output logic                        HMASTLOCK,
  input  logic [DATA_W-1:0]           HRDATA,
  input  logic                        HREADY,
  input  logic                        HRESP
);
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam bit USE_RR = (ARB_MODE == "RR");

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10
  } trans_t;

  logic              a_valid, a_write;
  logic [PW-1:0]     a_port;
  logic [ADDR_W-1:0] a_addr;
  logic [2:0]        a_size;
  logic [DATA_W-1:0] a_wdata;
  logic              d_valid, d_write;
  logic [PW-1:0]     d_port;
  logic [DATA_W-1:0] d_wdata;
  logic              err_hold;
  logic [PW-1:0]     ptr;

  logic              win_valid;
  logic [PW-1:0]     win_port;
  logic [PW-1:0]     cand_idx;
  int                cand;
  logic [2:0]        win_size;
  logic              advance, a_load;

  // Rotating search from ptr (RR) or from port 0 (FIXED); first requester wins.
  always_comb begin
    win_valid = 1'b0;
    win_port  = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (USE_RR ? int'(ptr) : 0) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = PW'(cand);
      if (!win_valid && p_req[cand_idx]) begin
        win_valid = 1'b1;
        win_port  = cand_idx;
      end
    end
  end

  always_comb begin
    win_size = p_size[win_port*3 +: 3];
    if (win_size > 3'b010) win_size = 3'b010;
  end

  assign advance = HREADY && !err_hold;
  assign a_load  = win_valid && (advance || !a_valid);

  always_comb begin
    p_ack = '0;
    if (a_load) p_ack[win_port] = 1'b1;
  end

  assign HTRANS    = (a_valid && !err_hold) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = a_addr;
  assign HWRITE    = a_write;
  assign HSIZE     = a_size;
  assign HWDATA    = d_wdata;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_port  <= '0;
      a_addr  <= '0;
      a_write <= 1'b0;
      a_size  <= 3'b010;
      a_wdata <= '0;
      ptr     <= '0;
    end else if (a_load) begin
      a_valid <= 1'b1;
      a_port  <= win_port;
      a_addr  <= p_addr[win_port*ADDR_W +: ADDR_W];
      a_write <= p_write[win_port];
      a_size  <= win_size;
      a_wdata <= p_wdata[win_port*DATA_W +: DATA_W];
      ptr     <= (int'(win_port) == NUM_PORTS - 1) ? '0 : win_port + 1'b1;
    end else if (advance) begin
      a_valid <= 1'b0;
    end
  end

  // During an error hold the data stage drains alone; the address stage stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_valid  <= 1'b0;
      d_port   <= '0;
      d_write  <= 1'b0;
      d_wdata  <= '0;
      err_hold <= 1'b0;
    end else begin
      if (advance) begin
        d_valid <= a_valid;
        d_port  <= a_port;
        d_write <= a_write;
        d_wdata <= a_wdata;
      end else if (HREADY) begin
        d_valid <= 1'b0;
      end
      if (err_hold) begin
        if (HREADY) err_hold <= 1'b0;
      end else if (HRESP && !HREADY) begin
        err_hold <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_done  <= '0;
      p_err   <= '0;
      p_rdata <= '0;
    end else begin
      p_done <= '0;
      p_err  <= '0;
      if (d_valid && HREADY) begin
        p_done[d_port] <= 1'b1;
        p_err[d_port]  <= HRESP;
        if (!d_write) p_rdata <= HRDATA;
      end
    end
  end
endmodule

// File: tb/tb_ahb_master_biu.sv
// Directed bench for ahb_master_biu: a 2-port FIXED instance for pipeline, wait,
// error and reset behaviour, plus a 3-port RR instance for arbitration order.
module tb_ahb_master_biu;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  p_req, p_write;
  logic [63:0] p_addr, p_wdata;
  logic [5:0]  p_size;
  logic [1:0]  p_ack, p_done, p_err;
  logic [31:0] p_rdata, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP;

  logic [2:0]  rr_req, rr_write, rr_ack, rr_done, rr_err;
  logic [95:0] rr_addr, rr_wdata;
  logic [8:0]  rr_size;
  logic [31:0] rr_rdata, rr_haddr, rr_hwdata;
  logic [1:0]  rr_htrans;
  logic        rr_hwrite, rr_hmastlock;
  logic [2:0]  rr_hsize, rr_hburst;
  logic [3:0]  rr_hprot;

  int checkCount = 0;
  int errorCount = 0;

  ahb_master_biu dut (
    .clk(clk), .reset(reset), .p_req(p_req), .p_addr(p_addr), .p_write(p_write),
    .p_size(p_size), .p_wdata(p_wdata), .p_ack(p_ack), .p_done(p_done), .p_err(p_err),
    .p_rdata(p_rdata), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  ahb_master_biu #(.NUM_PORTS(3), .ARB_MODE("RR")) dut_rr (
    .clk(clk), .reset(reset), .p_req(rr_req), .p_addr(rr_addr), .p_write(rr_write),
    .p_size(rr_size), .p_wdata(rr_wdata), .p_ack(rr_ack), .p_done(rr_done), .p_err(rr_err),
    .p_rdata(rr_rdata), .HADDR(rr_haddr), .HTRANS(rr_htrans), .HWRITE(rr_hwrite),
    .HSIZE(rr_hsize), .HWDATA(rr_hwdata), .HBURST(rr_hburst), .HPROT(rr_hprot),
    .HMASTLOCK(rr_hmastlock), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic [31:0] addr,
                               input logic write, input logic [2:0] size, input logic [31:0] wdata);
    p_req[port]             = req;
    p_addr[port*32 +: 32]   = addr;
    p_write[port]           = write;
    p_size[port*3 +: 3]     = size;
    p_wdata[port*32 +: 32]  = wdata;
  endtask

  task automatic setSlave(input logic ready, input logic resp, input logic [31:0] rdata);
    HREADY = ready;
    HRESP  = resp;
    HRDATA = rdata;
  endtask

  logic [2:0] rrExpected [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    reset = 1'b1;
    p_req = '0; p_write = '0; p_addr = '0; p_wdata = '0; p_size = '0;
    rr_req = '0; rr_write = '0; rr_addr = '0; rr_wdata = '0; rr_size = '0;
    setSlave(1'b1, 1'b0, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("rst_htrans", HTRANS, 2'b00);
    checkOutput("rst_haddr", HADDR, 32'h0);
    checkOutput("rst_hsize", HSIZE, 3'b010);
    checkOutput("rst_hwdata", HWDATA, 32'h0);
    checkOutput("rst_ack", p_ack, 2'b00);
    checkOutput("rst_done", p_done, 2'b00);
    checkOutput("rst_rdata", p_rdata, 32'h0);
    checkOutput("const_bus", {HBURST, HPROT, HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
    reset = 1'b0;
    nextCycle();

    // Single read from port 1, zero waits
    applyStimulus(1, 1'b1, 32'h100, 1'b0, 3'b001, 32'h0);
    #1 checkOutput("rd_ack_c0", p_ack, 2'b10);
    nextCycle();
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    #1 checkOutput("rd_htrans_c1", HTRANS, 2'b10);
    checkOutput("rd_haddr_c1", HADDR, 32'h100);
    checkOutput("rd_hwrite_c1", HWRITE, 1'b0);
    checkOutput("rd_hsize_c1", HSIZE, 3'b001);
    checkOutput("rd_ack_c1", p_ack, 2'b00);
    nextCycle();
    setSlave(1'b1, 1'b0, 32'hDEADBEEF);
    #1 checkOutput("rd_htrans_c2", HTRANS, 2'b00);
    checkOutput("rd_done_c2", p_done, 2'b00);
    nextCycle();
    setSlave(1'b1, 1'b0, 32'h0);
    #1 checkOutput("rd_done_c3", p_done, 2'b10);
    checkOutput("rd_rdata_c3", p_rdata, 32'hDEADBEEF);
    checkOutput("rd_err_c3", p_err, 2'b00);
    nextCycle();

    // Back-to-back writes from port 1, two wait states each
    applyStimulus(1, 1'b1, 32'h200, 1'b1, 3'b000, 32'h11);
    #1 checkOutput("wr_ack_c0", p_ack, 2'b10);
    nextCycle();
    applyStimulus(1, 1'b1, 32'h204, 1'b1, 3'b101, 32'h22);
    #1 checkOutput("wr_haddr_c1", HADDR, 32'h200);
    checkOutput("wr_hsize_c1", HSIZE, 3'b000);
    checkOutput("wr_hwrite_c1", HWRITE, 1'b1);
    checkOutput("wr_ack_c1", p_ack, 2'b10);
    nextCycle();
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    setSlave(1'b0, 1'b0, 32'h0);
    #1 checkOutput("wr_hwdata_w1", HWDATA, 32'h11);
    checkOutput("wr_haddr_overlap", HADDR, 32'h204);
    checkOutput("wr_htrans_overlap", HTRANS, 2'b10);
    checkOutput("wr_hsize_clamp", HSIZE, 3'b010);
    nextCycle();
    #1 checkOutput("wr_hwdata_w2", HWDATA, 32'h11);
    checkOutput("wr_done_w2", p_done, 2'b00);
    nextCycle();
    setSlave(1'b1, 1'b0, 32'h0);
    #1 checkOutput("wr_hwdata_rdy", HWDATA, 32'h11);
    nextCycle();
    setSlave(1'b0, 1'b0, 32'h0);
    #1 checkOutput("wr_done_first", p_done, 2'b10);
    checkOutput("wr_hwdata_second", HWDATA, 32'h22);
    checkOutput("wr_htrans_idle", HTRANS, 2'b00);
    checkOutput("wr_rdata_kept", p_rdata, 32'hDEADBEEF);
    nextCycle();
    #1 checkOutput("wr_done_gap", p_done, 2'b00);
    nextCycle();
    setSlave(1'b1, 1'b0, 32'h0);
    nextCycle();
    #1 checkOutput("wr_done_second", p_done, 2'b10);
    nextCycle();

    // FIXED arbitration: both ports requesting continuously
    applyStimulus(0, 1'b1, 32'h1000, 1'b0, 3'b010, 32'h0);
    applyStimulus(1, 1'b1, 32'h2000, 1'b0, 3'b010, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1 checkOutput($sformatf("fixed_ack_%0d", i), p_ack, 2'b01);
      nextCycle();
    end
    checkOutput("fixed_done_p0", p_done, 2'b01);
    p_req = '0;
    for (int i = 0; i < 3; i++) nextCycle();

    // RR arbitration on the 3-port instance
    rr_req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 checkOutput($sformatf("rr_ack_%0d", i), rr_ack, rrExpected[i]);
      nextCycle();
    end
    rr_req = '0;
    for (int i = 0; i < 3; i++) nextCycle();

    // Two-cycle ERROR on read 0x300 with 0x304 pending
    applyStimulus(1, 1'b1, 32'h300, 1'b0, 3'b010, 32'h0);
    #1 checkOutput("err_ack_c0", p_ack, 2'b10);
    nextCycle();
    applyStimulus(1, 1'b1, 32'h304, 1'b0, 3'b010, 32'h0);
    #1 checkOutput("err_ack_c1", p_ack, 2'b10);
    nextCycle();
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    setSlave(1'b0, 1'b1, 32'h0);
    #1 checkOutput("err_htrans_e1", HTRANS, 2'b10);
    checkOutput("err_haddr_e1", HADDR, 32'h304);
    nextCycle();
    setSlave(1'b1, 1'b1, 32'h0);
    #1 checkOutput("err_htrans_e2", HTRANS, 2'b00);
    checkOutput("err_done_e2", p_done, 2'b00);
    nextCycle();
    setSlave(1'b1, 1'b0, 32'h0);
    #1 checkOutput("err_done", p_done, 2'b10);
    checkOutput("err_perr", p_err, 2'b10);
    checkOutput("err_reissue_htrans", HTRANS, 2'b10);
    checkOutput("err_reissue_haddr", HADDR, 32'h304);
    checkOutput("err_no_reack", p_ack, 2'b00);
    nextCycle();
    setSlave(1'b1, 1'b0, 32'h12345678);
    #1 checkOutput("err_done_gap", p_done, 2'b00);
    nextCycle();
    setSlave(1'b1, 1'b0, 32'h0);
    #1 checkOutput("err_second_done", p_done, 2'b10);
    checkOutput("err_second_perr", p_err, 2'b00);
    checkOutput("err_second_rdata", p_rdata, 32'h12345678);
    nextCycle();

    // Reset during a waited data phase
    applyStimulus(0, 1'b1, 32'h400, 1'b0, 3'b010, 32'h0);
    nextCycle();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    nextCycle();
    setSlave(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1 checkOutput("rstmid_htrans", HTRANS, 2'b00);
    checkOutput("rstmid_done", p_done, 2'b00);
    nextCycle();
    reset = 1'b0;
    setSlave(1'b1, 1'b0, 32'h0);
    #1 checkOutput("rstmid_done_after", p_done, 2'b00);
    nextCycle();
    #1 checkOutput("rstmid_done_after2", p_done, 2'b00);
    applyStimulus(0, 1'b1, 32'h500, 1'b0, 3'b010, 32'h0);
    #1 checkOutput("post_ack", p_ack, 2'b01);
    nextCycle();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    #1 checkOutput("post_haddr", HADDR, 32'h500);
    nextCycle();
    setSlave(1'b1, 1'b0, 32'hCAFEF00D);
    nextCycle();
    #1 checkOutput("post_done", p_done, 2'b01);
    checkOutput("post_rdata", p_rdata, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/ahb_master_biu.md
AHB_MASTER_BIU -- requirements
Module: ahb_master_biu

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requester channels (1..8); index 0 is the instruction fetch port, index 1 is the data port.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Parameter ARB_MODE, default "FIXED": arbitration mode, "FIXED" or "RR".
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 p_req  input  NUM_PORTS  per-port request; held with its payload until acked.
REQ-008 p_addr  input  NUM_PORTS*ADDR_W  per-port address.
REQ-009 p_write  input  NUM_PORTS  per-port direction, 1 = write.
REQ-010 p_size  input  NUM_PORTS*3  per-port HSIZE encoding.
REQ-011 p_wdata  input  NUM_PORTS*DATA_W  per-port write data.
REQ-012 p_ack  output  NUM_PORTS  one-hot; request accepted at this edge.
REQ-013 p_done  output  NUM_PORTS  one-hot, one-cycle pulse; transfer completed.
REQ-014 p_err  output  NUM_PORTS  one-hot, qualified by p_done; slave ERROR response.
REQ-015 p_rdata  output  DATA_W  read data, valid while p_done is high.
REQ-016 HADDR, HTRANS[1:0], HWRITE, HSIZE[2:0], HWDATA  outputs  AHB-Lite master signals.
REQ-017 HBURST[2:0], HPROT[3:0], HMASTLOCK  outputs  constants 3'b000 (SINGLE), 4'b0011, 1'b0.
REQ-018 HRDATA  input  DATA_W; HREADY, HRESP  inputs  1.

Function
REQ-019 The block SHALL have two stages: an address stage (valid, port, addr, write, size, wdata) and a data stage (valid, port, write, wdata), allowing at most 2 transfers in flight.
REQ-020 HADDR, HWRITE and HSIZE SHALL be driven from the address stage; HTRANS SHALL be NONSEQ (2'b10) when the address stage is valid and err_hold=0, and IDLE otherwise.
REQ-021 HWDATA SHALL be driven from the data stage wdata.
REQ-022 An advance SHALL occur at an edge with HREADY=1 and err_hold=0: the data stage completes (if valid), the address stage moves to the data stage, and the arbiter winner (if any) loads the address stage.
REQ-023 The address stage SHALL also load when it is empty, regardless of HREADY.
REQ-024 p_ack[k] SHALL be combinational, high in the cycle in which port k wins and a load occurs at the next edge; otherwise it SHALL be low.
REQ-025 FIXED mode: the lowest-index requesting port SHALL win.
REQ-026 RR mode: the search SHALL start at pointer ptr; after a grant to port k, ptr SHALL become (k+1) mod NUM_PORTS.
REQ-027 Data-stage completion at an edge with HREADY=1 SHALL, in the next cycle, assert p_done[port], set p_rdata to HRDATA (reads; writes leave p_rdata unchanged), and set p_err[port]=HRESP.
REQ-028 An edge with HRESP=1 and HREADY=0 (first error cycle) SHALL set err_hold=1; err_hold SHALL clear at the next edge with HREADY=1.
REQ-029 While err_hold=1, HTRANS SHALL be IDLE; at the HREADY=1 edge the data stage SHALL complete with p_err, and the address-stage transfer SHALL remain and be re-driven as NONSEQ in the following cycle (no re-ack).
REQ-030 p_size values above 3'b010 SHALL be issued as 3'b010.
REQ-031 Zero-wait latency: req at cycle 0 with the bus idle gives p_ack in cycle 0, NONSEQ in cycle 1, data phase in cycle 2, and p_done in cycle 3.
REQ-032 Simultaneous completion of port k and a new ack to port k in the same cycle SHALL be legal.

Reset
REQ-033 On reset: both stage valids=0, err_hold=0, ptr=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0, p_ack=0, p_done=0, p_err=0, p_rdata=0.
REQ-034 Reset mid-transfer SHALL abandon all in-flight transfers without asserting p_done.

Verification
REQ-035 Single read, port 1, addr 0x100, HRDATA=0xDEADBEEF, no waits -> p_ack cycle 0, HADDR=0x100 with NONSEQ cycle 1, p_done[1] with p_rdata=0xDEADBEEF cycle 3.
REQ-036 Back-to-back writes 0x200/0x11, 0x204/0x22 from port 1 with 2 wait states each -> HWDATA 0x11 held across the waits, address 0x204 overlaps data 0x11, two p_done pulses in order.
REQ-037 Both ports requesting continuously, FIXED mode -> port 0 wins every time; RR mode, NUM_PORTS=3 -> grants 0,1,2,0,1,2.
REQ-038 Two-cycle ERROR on a read at 0x300 with 0x304 pending -> HTRANS=IDLE in the second error cycle, p_done and p_err for 0x300, 0x304 re-issued and completes with no error.
REQ-039 Reset asserted during a waited data phase -> HTRANS=IDLE, no p_done; a new request after reset completes normally.
